// File: rtl/cordic_nco_phase_gen_pkg.sv
// Shared encodings for the CORDIC NCO phase generator: configuration
// register addresses and the run-control FSM state.
package cordic_nco_phase_gen_pkg;

    localparam logic [1:0] ADDR_FTW = 2'd0;
    localparam logic [1:0] ADDR_POW = 2'd1;
    localparam logic [1:0] ADDR_AMP = 2'd2;
    localparam logic [1:0] ADDR_DIV = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BURST = 2'd2
    } state_e;

endpackage

// File: rtl/cordic_nco_phase_gen_if.sv
// Control/config/sample bundle between a controller (master) and the
// phase generator (slave).
//
// Handshake: po_dv is a valid-only strobe with no ready/backpressure. Each
// cycle with po_dv high carries exactly one sample. po_x/po_y/po_z are stable
// while po_dv is high and hold their last values otherwise. done is a
// one-cycle pulse coincident with the final po_dv of a burst. All control
// inputs (cfg_wr, cfg_apply, start, stop, phase_clr) are single-cycle pulses
// sampled on the rising clock edge.
interface cordic_nco_phase_gen_if #(
    parameter int IDW = 12,
    parameter int AW  = 20,
    parameter int BLW = 16
);
    logic           cfg_wr;
    logic [1:0]     cfg_addr;
    logic [31:0]    cfg_data;
    logic           cfg_apply;
    logic           start;
    logic           stop;
    logic           phase_clr;
    logic [BLW-1:0] burst_len;
    logic           busy;
    logic           done;
    logic           po_dv;
    logic [IDW-1:0] po_x;
    logic [IDW-1:0] po_y;
    logic [AW-1:0]  po_z;

    modport master (
        output cfg_wr, cfg_addr, cfg_data, cfg_apply, start, stop, phase_clr, burst_len,
        input  busy, done, po_dv, po_x, po_y, po_z
    );

    modport slave (
        input  cfg_wr, cfg_addr, cfg_data, cfg_apply, start, stop, phase_clr, burst_len,
        output busy, done, po_dv, po_x, po_y, po_z
    );
endinterface

// File: rtl/cordic_nco_phase_acc.sv
// Phase accumulator: steps by FTW on each sample tick, clears on request,
// and presents the offset phase truncated to the output width.
module cordic_nco_phase_acc #(
    parameter int PW = 32,
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic          clr,
    input  logic [PW-1:0] ftw,
    input  logic [PW-1:0] pow,
    output logic [AW-1:0] phase
);

    logic [PW-1:0] acc_q, acc_d;

    // Next accumulator value: clear beats step, so a tick coinciding with a
    // clear lands on 0 rather than on FTW.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (step) begin
            acc_d = acc_q + ftw;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Offset phase from the current (pre-step) accumulator, top AW bits kept.
    assign phase = AW'((acc_q + pow) >> (PW - AW));

endmodule

// File: rtl/cordic_nco_phase_gen.sv
// NCO-mode CORDIC upstream driver: sample-rate divider, phase accumulator
// with offset, constant amplitude, continuous or burst generation, and
// shadow/active configuration switched only on sample boundaries.
module cordic_nco_phase_gen
    import cordic_nco_phase_gen_pkg::*;
#(
    parameter int IDW  = 12,
    parameter int AW   = 20,
    parameter int PW   = 32,
    parameter int DIVW = 16,
    parameter int BLW  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cordic_nco_phase_gen_if.slave bus,
    output state_e                dbg_state
);

    logic [PW-1:0]   ftw_sh_q, ftw_sh_d, pow_sh_q, pow_sh_d;
    logic [IDW-1:0]  amp_sh_q, amp_sh_d;
    logic [DIVW-1:0] div_sh_q, div_sh_d;
    logic [PW-1:0]   ftw_q, ftw_d, pow_q, pow_d;
    logic [IDW-1:0]  amp_q, amp_d;
    logic [DIVW-1:0] div_q, div_d;
    logic            pend_q, pend_d;
    state_e          state_q, state_d;
    logic [DIVW-1:0] cnt_q, cnt_d;
    logic [BLW-1:0]  bcnt_q, bcnt_d;
    logic            done_q, done_d;
    logic            po_dv_q, po_dv_d;
    logic [IDW-1:0]  po_x_q, po_x_d;
    logic [AW-1:0]   po_z_q, po_z_d;
    logic            busy, tick, pend_now;
    logic [AW-1:0]   phase;

    assign busy = (state_q != S_IDLE);
    // A stop in the same cycle suppresses the tick entirely.
    assign tick = busy && !bus.stop && (cnt_q == div_q);

    cordic_nco_phase_acc #(.PW(PW), .AW(AW)) u_acc (
        .clk   (clk),
        .rst   (rst),
        .step  (tick),
        .clr   (bus.phase_clr),
        .ftw   (ftw_q),
        .pow   (pow_q),
        .phase (phase)
    );

    // Shadow register writes; the active set is untouched here.
    always_comb begin
        ftw_sh_d = ftw_sh_q;
        pow_sh_d = pow_sh_q;
        amp_sh_d = amp_sh_q;
        div_sh_d = div_sh_q;
        if (bus.cfg_wr) begin
            case (bus.cfg_addr)
                ADDR_FTW: ftw_sh_d = PW'(bus.cfg_data);
                ADDR_POW: pow_sh_d = PW'(bus.cfg_data);
                ADDR_AMP: amp_sh_d = IDW'(bus.cfg_data);
                ADDR_DIV: div_sh_d = DIVW'(bus.cfg_data);
            endcase
        end
    end

    // Shadow-to-active copy: immediate in IDLE, otherwise held pending until
    // the next tick so that the tick itself still uses the old values.
    always_comb begin
        ftw_d    = ftw_q;
        pow_d    = pow_q;
        amp_d    = amp_q;
        div_d    = div_q;
        pend_now = pend_q || bus.cfg_apply;
        pend_d   = pend_q;
        if (!busy) begin
            pend_d = 1'b0;
            if (bus.cfg_apply) begin
                ftw_d = ftw_sh_q;
                pow_d = pow_sh_q;
                amp_d = amp_sh_q;
                div_d = div_sh_q;
            end
        end else if (bus.stop) begin
            pend_d = 1'b0;
        end else if (tick && pend_now) begin
            pend_d = 1'b0;
            ftw_d  = ftw_sh_q;
            pow_d  = pow_sh_q;
            amp_d  = amp_sh_q;
            div_d  = div_sh_q;
        end else begin
            pend_d = pend_now;
        end
    end

    // Sample-rate divider: counts 0..DIV while busy, wraps on tick.
    always_comb begin
        if (!busy || bus.stop || bus.phase_clr || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIVW'(1);
        end
    end

    // Run-control FSM next state, burst countdown and done pulse.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    if (bus.burst_len == '0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_BURST;
                        bcnt_d  = bus.burst_len;
                    end
                end
            end
            S_RUN: begin
                if (bus.stop) state_d = S_IDLE;
            end
            S_BURST: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    bcnt_d  = '0;
                end else if (tick) begin
                    bcnt_d = bcnt_q - BLW'(1);
                    if (bcnt_q == BLW'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered sample outputs: one cycle after the tick, hold otherwise.
    always_comb begin
        po_dv_d = tick;
        po_x_d  = po_x_q;
        po_z_d  = po_z_q;
        if (tick) begin
            po_x_d = amp_q;
            po_z_d = phase;
        end
    end

    // All control/config state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ftw_sh_q <= '0;
            pow_sh_q <= '0;
            amp_sh_q <= '0;
            div_sh_q <= '0;
            ftw_q    <= '0;
            pow_q    <= '0;
            amp_q    <= '0;
            div_q    <= '0;
            pend_q   <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bcnt_q   <= '0;
            done_q   <= 1'b0;
            po_dv_q  <= 1'b0;
            po_x_q   <= '0;
            po_z_q   <= '0;
        end else begin
            ftw_sh_q <= ftw_sh_d;
            pow_sh_q <= pow_sh_d;
            amp_sh_q <= amp_sh_d;
            div_sh_q <= div_sh_d;
            ftw_q    <= ftw_d;
            pow_q    <= pow_d;
            amp_q    <= amp_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bcnt_q   <= bcnt_d;
            done_q   <= done_d;
            po_dv_q  <= po_dv_d;
            po_x_q   <= po_x_d;
            po_z_q   <= po_z_d;
        end
    end

    assign bus.busy  = busy;
    assign bus.done  = done_q;
    assign bus.po_dv = po_dv_q;
    assign bus.po_x  = po_x_q;
    assign bus.po_y  = '0;
    assign bus.po_z  = po_z_q;
    assign dbg_state = state_q;

endmodule
